// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier for the ALU MUL operation; stalls the pipeline while busy.
// Build option: define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module alu_mul_seq #(
    parameter int         DATA_W   = 32,
    parameter logic [3:0] MUL_CODE = 4'b1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                launch;
    logic                lastStep;

    assign launch = (state_q == IDLE) && start_i && (ALUCtrl_i == MUL_CODE) && !flush_i;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        lastStep = 1'b0;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    mcand_d  = src1_i;
                    mplier_d = src2_i;
                    acc_d    = '0;
                    count_d  = CNT_W'(DATA_W);
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q - CNT_W'(1);
`ifdef MUL_EARLY_EXIT_EN
                    lastStep = (count_d == '0) || (mplier_d == '0);
`else
                    lastStep = (count_d == '0);
`endif
                    // Capture the final sum on the way into DONE so result_o is valid with done_o.
                    if (lastStep) begin
                        result_d = acc_d;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // A flush releases the stall in the same cycle it aborts the run.
    assign stall_o  = launch || ((state_q == RUN) && !flush_i);
    assign ready_o  = (state_q == IDLE);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule
